// File: rtl/vend_credit_fsm.sv
// Coin-credit accumulator: collects coin credit against PRICE, pulses vend, pays change per handshake.
// Optional refund-on-cancel path is compiled in with `define VEND_CANCEL_EN.
module vend_credit_fsm #(
    parameter int unsigned PRICE     = 5,
    parameter int unsigned COIN1_VAL = 1,
    parameter int unsigned COIN2_VAL = 2,
    parameter int unsigned COIN3_VAL = 4,
    parameter int unsigned CREDIT_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                chg_ready,
    output logic                coin_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                chg_valid,
    output logic [CREDIT_W-1:0] chg_left,
    output logic                refund
);

    typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

    localparam int unsigned Max12   = (COIN1_VAL > COIN2_VAL) ? COIN1_VAL : COIN2_VAL;
    localparam int unsigned MaxCoin = (Max12 > COIN3_VAL) ? Max12 : COIN3_VAL;
    localparam int unsigned MaxHeld = PRICE - 1 + MaxCoin;
    localparam int unsigned MaxCode = (1 << CREDIT_W) - 1;

    localparam logic [CREDIT_W:0] PriceW = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W:0] Coin1W = (CREDIT_W + 1)'(COIN1_VAL);
    localparam logic [CREDIT_W:0] Coin2W = (CREDIT_W + 1)'(COIN2_VAL);
    localparam logic [CREDIT_W:0] Coin3W = (CREDIT_W + 1)'(COIN3_VAL);

    if (PRICE < 1 || MaxHeld > MaxCode) begin : g_param_check
        $error("vend_credit_fsm: PRICE must be >= 1 and CREDIT_W must hold PRICE-1+max coin");
    end

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] chg_left_q, chg_left_d;
    logic                vend_q, vend_d;
    logic                chg_valid_q, chg_valid_d;
    logic                refund_q, refund_d;

    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W:0]   over;
    logic                cancel_en;

`ifdef VEND_CANCEL_EN
    assign cancel_en = cancel;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_en     = 1'b0;
`endif

    always_comb begin
        coin_val = '0;
        unique case (coin)
            2'b01:   coin_val = Coin1W;
            2'b10:   coin_val = Coin2W;
            2'b11:   coin_val = Coin3W;
            default: coin_val = '0;
        endcase
        sum  = {1'b0, credit_q} + coin_val;
        over = sum - PriceW;
    end

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        chg_left_d  = chg_left_q;
        vend_d      = 1'b0;
        chg_valid_d = chg_valid_q;
        refund_d    = refund_q;

        unique case (state_q)
            StIdle, StCollect: begin
                if (cancel_en) begin
                    // Refund whatever is held plus the coin arriving now, even past PRICE.
                    credit_d = '0;
                    if (sum == '0) begin
                        state_d = StIdle;
                    end else begin
                        state_d     = StChange;
                        chg_left_d  = sum[CREDIT_W-1:0];
                        chg_valid_d = 1'b1;
                        refund_d    = 1'b1;
                    end
                end else if (sum == '0) begin
                    state_d  = StIdle;
                    credit_d = '0;
                end else if (sum < PriceW) begin
                    state_d  = StCollect;
                    credit_d = sum[CREDIT_W-1:0];
                end else begin
                    state_d    = StVend;
                    credit_d   = '0;
                    chg_left_d = over[CREDIT_W-1:0];
                    vend_d     = 1'b1;
                end
            end
            StVend: begin
                if (chg_left_q != '0) begin
                    state_d     = StChange;
                    chg_valid_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StChange: begin
                if (chg_ready) begin
                    chg_left_d = chg_left_q - CREDIT_W'(1);
                    if (chg_left_q == CREDIT_W'(1)) begin
                        state_d     = StIdle;
                        chg_valid_d = 1'b0;
                        refund_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                credit_d    = '0;
                chg_left_d  = '0;
                chg_valid_d = 1'b0;
                refund_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            credit_q    <= '0;
            chg_left_q  <= '0;
            vend_q      <= 1'b0;
            chg_valid_q <= 1'b0;
            refund_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            chg_left_q  <= chg_left_d;
            vend_q      <= vend_d;
            chg_valid_q <= chg_valid_d;
            refund_q    <= refund_d;
        end
    end

    assign coin_ready = (state_q == StIdle) || (state_q == StCollect);
    assign credit     = credit_q;
    assign chg_left   = chg_left_q;
    assign vend       = vend_q;
    assign chg_valid  = chg_valid_q;
`ifdef VEND_CANCEL_EN
    assign refund     = refund_q;
`else
    logic unused_refund;
    assign unused_refund = refund_q;
    assign refund        = 1'b0;
`endif

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm: default-parameter instance plus a PRICE=7, coins 1/3/5 instance.
module tb_vend_credit_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] coin, coin2;
    logic       cancel, cancel2, chg_ready, chg_ready2;
    logic       coin_ready, vend, chg_valid, refund;
    logic [3:0] credit, chg_left;
    logic       coin_ready2, vend2, chg_valid2, refund2;
    logic [3:0] credit2, chg_left2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vend_credit_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin       (coin),
        .cancel     (cancel),
        .chg_ready  (chg_ready),
        .coin_ready (coin_ready),
        .credit     (credit),
        .vend       (vend),
        .chg_valid  (chg_valid),
        .chg_left   (chg_left),
        .refund     (refund)
    );

    vend_credit_fsm #(
        .PRICE     (7),
        .COIN1_VAL (1),
        .COIN2_VAL (3),
        .COIN3_VAL (5),
        .CREDIT_W  (4)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin       (coin2),
        .cancel     (cancel2),
        .chg_ready  (chg_ready2),
        .coin_ready (coin_ready2),
        .credit     (credit2),
        .vend       (vend2),
        .chg_valid  (chg_valid2),
        .chg_left   (chg_left2),
        .refund     (refund2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " credit"},     credit,     0);
        check({tag, " chg_left"},   chg_left,   0);
        check({tag, " vend"},       vend,       0);
        check({tag, " chg_valid"},  chg_valid,  0);
        check({tag, " refund"},     refund,     0);
        check({tag, " coin_ready"}, coin_ready, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        coin = 2'b00; cancel = 1'b0; chg_ready = 1'b0;
        coin2 = 2'b00; cancel2 = 1'b0; chg_ready2 = 1'b0;
        #2;
        check_reset_vals("reset");
        #10 rst_n = 1'b1;
        step();

        // 2+2+2 = 6 against price 5: one unit of change
        coin = 2'b10;
        step(); check("t1 credit a", credit, 2); check("t1 vend a", vend, 0);
        step(); check("t1 credit b", credit, 4);
        step(); check("t1 vend", vend, 1); check("t1 chg_left", chg_left, 1);
        check("t1 credit c", credit, 0); check("t1 coin_ready vend", coin_ready, 0);
        coin = 2'b00; chg_ready = 1'b1;
        step(); check("t1 chg_valid", chg_valid, 1); check("t1 vend off", vend, 0);
        step(); check("t1 chg_valid off", chg_valid, 0); check("t1 chg_left 0", chg_left, 0);
        check("t1 coin_ready idle", coin_ready, 1);
        chg_ready = 1'b0;

        // 4+4 = 8: three units, ready pattern 1,0,1,1
        coin = 2'b11;
        step(); check("t2 credit", credit, 4);
        step(); check("t2 vend", vend, 1); check("t2 chg_left", chg_left, 3);
        coin = 2'b00;
        step(); check("t2 chg_valid", chg_valid, 1); check("t2 left3", chg_left, 3);
        chg_ready = 1'b1; step(); check("t2 left2", chg_left, 2); check("t2 v1", chg_valid, 1);
        chg_ready = 1'b0; step(); check("t2 hold2", chg_left, 2); check("t2 v2", chg_valid, 1);
        chg_ready = 1'b1; step(); check("t2 left1", chg_left, 1); check("t2 v3", chg_valid, 1);
        step(); check("t2 left0", chg_left, 0); check("t2 v4", chg_valid, 0);
        chg_ready = 1'b0;

        // Exact price with coin 01 x5; coin during VEND dropped, next coin in IDLE accepted
        coin = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            step(); check("t3 credit", credit, i);
        end
        step(); check("t3 vend", vend, 1); check("t3 chg_left", chg_left, 0);
        coin = 2'b10;
        step(); check("t3 idle credit", credit, 0); check("t3 no chg", chg_valid, 0);
        check("t3 coin_ready", coin_ready, 1); check("t3 vend off", vend, 0);
        step(); check("t3 b2b credit", credit, 2);
        coin = 2'b01; step(); check("t4 credit3", credit, 3);
        coin = 2'b11; step(); check("t4 vend", vend, 1); check("t4 chg_left", chg_left, 2);
        coin = 2'b00; step(); check("t4 chg_valid", chg_valid, 1);

        // Asynchronous reset mid-CHANGE
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async rst");
        #1 rst_n = 1'b1;
        step();
        coin = 2'b10; step(); check("t5 credit", credit, 2);
        coin = 2'b01; step(); check("t5 credit3", credit, 3);

`ifdef VEND_CANCEL_EN
        cancel = 1'b1; coin = 2'b11;
        step(); check("t6 vend", vend, 0); check("t6 refund", refund, 1);
        check("t6 chg_valid", chg_valid, 1); check("t6 chg_left", chg_left, 7);
        check("t6 credit", credit, 0);
        cancel = 1'b0; coin = 2'b00; chg_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            check("t6 left", chg_left, 7 - i);
            check("t6 valid", chg_valid, (i < 7) ? 1 : 0);
        end
        check("t6 refund off", refund, 0);
        chg_ready = 1'b0;
`else
        cancel = 1'b1; coin = 2'b11;
        step(); check("t6 vend", vend, 1); check("t6 refund", refund, 0);
        check("t6 chg_left", chg_left, 2);
        cancel = 1'b0; coin = 2'b00; chg_ready = 1'b1;
        step(); check("t6 chg_valid", chg_valid, 1); check("t6 left2", chg_left, 2);
        check("t6 refund chg", refund, 0);
        step(); check("t6 left1", chg_left, 1);
        step(); check("t6 left0", chg_left, 0); check("t6 valid off", chg_valid, 0);
        chg_ready = 1'b0;
`endif

        // PRICE=7 instance: 5+5 = 10 -> vend, three units change
        coin2 = 2'b11;
        step(); check("p7 credit", credit2, 5);
`ifndef VEND_CANCEL_EN
        cancel2 = 1'b1;
`endif
        step(); check("p7 vend", vend2, 1); check("p7 chg_left", chg_left2, 3);
        check("p7 refund", refund2, 0);
        coin2 = 2'b00; cancel2 = 1'b0; chg_ready2 = 1'b1;
        step(); check("p7 chg_valid", chg_valid2, 1);
        n = 0;
        for (int k = 0; k < 10 && chg_valid2; k++) begin
            step();
            n++;
        end
        check("p7 units", n, 3);
        check("p7 valid off", chg_valid2, 0);
        check("p7 coin_ready", coin_ready2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vend_credit_fsm.md
# vend_credit_fsm

Registered, parametrised successor to the combinational 9-state coin-accumulator next-state decoder. The block accumulates coin credit against a configurable price, pulses `vend` when the price is met, and returns overpayment or a cancelled credit one unit per handshake. It replaces the external state register and the output encoder around the old decoder, and sits between the coin-input debouncer and the dispenser/change-hopper drivers.

## Interface
- `PRICE`, 5, vend price in credit units; must be ≥1.
- `COIN1_VAL`, 1, credit value of coin code 2'b01.
- `COIN2_VAL`, 2, credit value of coin code 2'b10.
- `COIN3_VAL`, 4, credit value of coin code 2'b11.
- `CREDIT_W`, 4, width of credit/change counters; must hold `PRICE-1+max(COINn_VAL)` (elaboration-time assertion).

- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `coin` in 2 — coin code; 2'b00 = no coin.
- `cancel` in 1 — request refund of current credit (only with `VEND_CANCEL_EN`).
- `chg_ready` in 1 — hopper accepts one change unit this cycle.
- `coin_ready` out 1 — coin code is sampled this cycle.
- `credit` out CREDIT_W — currently held credit.
- `vend` out 1 — one-cycle dispense pulse.
- `chg_valid` out 1 — a change unit is offered.
- `chg_left` out CREDIT_W — change units still owed.
- `refund` out 1 — current CHANGE sequence is a cancel refund, not overpayment.

## Operation
- States: IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND, CHANGE.
- Coin value v: 00→0, 01→COIN1_VAL, 10→COIN2_VAL, 11→COIN3_VAL. `coin_ready` = 1 in IDLE/COLLECT only. Coins in VEND/CHANGE are ignored, not queued.
- IDLE/COLLECT, sum = credit + v:
  - sum = 0 → IDLE.
  - 0 < sum < PRICE → COLLECT, credit = sum.
  - sum ≥ PRICE → VEND, credit = 0, chg_left = sum − PRICE.
- VEND lasts exactly one cycle, with `vend` = 1. Next state is CHANGE if chg_left > 0, else IDLE.
- CHANGE: `chg_valid` = 1. Each cycle with `chg_ready` = 1 decrements chg_left. The transfer that brings chg_left to 0 returns the FSM to IDLE, and `refund` clears.
- Held credit saturates at no value: the CREDIT_W constraint guarantees no overflow. Arithmetic is unsigned at CREDIT_W+1 bits before compare.
- Cancel (when compiled in), in IDLE/COLLECT with `cancel` = 1:
  - Cancel takes priority over vend.
  - refund amount = credit + v, even if ≥ PRICE. No vend.
  - If the amount is 0 → IDLE, else CHANGE with `refund` = 1 and chg_left = amount, credit = 0.
  - `cancel` is ignored in VEND/CHANGE.
- Reset (any time, including mid-CHANGE): state IDLE, all counters 0, owed change discarded.

## Timing
- All outputs are registered except `coin_ready`, which is decoded from state only.
- Reset values: credit 0, chg_left 0, vend 0, chg_valid 0, refund 0, coin_ready 1.
- Coin sampled at edge N: `credit` updates after edge N. If the price is met, `vend` is high for the cycle after edge N, and `chg_valid` first rises after edge N+1.
- Cancel sampled at edge N → `chg_valid`/`refund` high after edge N. No VEND cycle.
- chg handshake: a unit transfers on any edge where `chg_valid` & `chg_ready`. `chg_valid` never drops before chg_left reaches 0. `chg_ready` may be held high (one unit per cycle).
- Back-to-back purchases: the minimum is a coin on the cycle IDLE is re-entered, which is accepted.

## Configuration
- `VEND_CANCEL_EN` defined: `cancel` port is active, the refund path is as above, and `refund` can assert.
- `VEND_CANCEL_EN` undefined:
  - `cancel` is still present but ignored.
  - `refund` is tied 0.
  - CHANGE is entered only from VEND.

## Test plan
- Defaults. Coin codes 10,10,10 on consecutive cycles → credit 2, 4. Then `vend` pulse, chg_left 1, one unit transferred with chg_ready = 1, then IDLE.
- Coin 11 then 11 → credit 4. Then `vend`, chg_left 3. With chg_ready toggling 1,0,1,1, transfers complete on cycles 1, 3 and 4, and `chg_valid` stays high until chg_left = 0.
- Coin 01 ×5 → credit 1..4. The fifth coin gives `vend` with chg_left 0, back to IDLE with no `chg_valid`. Coins presented during VEND are dropped.
- `VEND_CANCEL_EN`: credit 3, then cancel + coin 11 in the same cycle → no vend, `refund` = 1, chg_left 7, 7 units returned.
- `rst_n` asserted asynchronously mid-CHANGE with chg_left 2 → all outputs at reset values immediately. After release, coin 10 → credit 2.
- Non-default `PRICE` = 7, coins 1/3/5, `CREDIT_W` = 4: coins 5,5 → `vend`, chg_left 3. Cancel ignored with the macro undefined.
